uart_tx: RTL and testbench
==========================

// Module: uart_tx
// PURPOSE
//   UART transmitter: serialises N-bit words onto a single line as
//   start bit, N data bits (MSB first), optional parity bit, STOP stop bits.
//   Bit order matches the team's UART receiver. Has a one-word holding buffer,
//   so a word can be queued while the previous frame is still on the line.
//   Sits between a host word interface and the TX pin.
// PARAMETERS
//   F      50_000_000  main clock frequency, Hz
//   BR     115_200     bitrate, bit/s
//   L      F/BR        clocks per bit; legal range 2..65535
//   N      8           data word width
//   M      3           data bit counter width; 2**M >= N
//   PARITY 0           0 = none, 1 = even, 2 = odd
//   STOP   1           number of stop bits, 1 or 2
// PORTS
//   clk    in   1  main clock, all logic on posedge
//   nrst   in   1  reset, asynchronous, active-low
//   d      in   N  word to send
//   valid  in   1  d is valid; accepted on posedge when valid & ready
//   ready  out  1  holding buffer empty, can accept a word
//   out    out  1  serial line, idle high
//   done   out  1  one-clk pulse at end of each frame's last stop bit
// BEHAVIOUR
//   Reset values: out=1, ready=1, done=0, FSM=IDLE, buffer empty.
//   Reset is async; any frame in flight is abandoned and the buffered word dropped.
//   Handshake:
//   - accept when valid & ready at a posedge: d -> buffer, ready=0 from next cycle.
//   - valid while ready=0 is ignored. d is not sampled and may change freely.
//   FSM states: IDLE, START, DATA, PAR, STOPB. All outputs are registered.
//   - IDLE: out=1. If buffer full, next edge: buffer -> shift reg, buffer
//     empty (ready=1), enter START.
//   - START: out=0 for L clks.
//   - DATA: N bits, MSB first, L clks each.
//   - PAR: present only if PARITY!=0. Bit = ^word (even) or ~^word (odd). L clks.
//   - STOPB: out=1 for STOP*L clks. On the final clk, done=1.
//     If buffer full -> START next edge (zero idle gap) with buffer reload.
//     Otherwise -> IDLE.
//   Latency: accept at edge k with FSM IDLE -> out falls at edge k+1.
//   Frame = (1+N+(PARITY!=0)+STOP)*L clks exactly; no jitter between bits.
//   Counters:
//   - 16-bit length counter: 0..L-1, wraps, advances the bit.
//   - M-bit bit counter: counts data and stop bits, cleared on state entry.
//   Accept and buffer reload never coincide (reload requires buffer full,
//   i.e. ready=0), so no same-edge conflict.
//   A word accepted during START..STOPB is sent back-to-back after the frame.
//   A word accepted in IDLE is sent immediately.
// TESTING (F=1_000_000, BR=250_000 -> L=4)
//   1. PARITY=0, STOP=1: send 8'hA5 -> out = 0,1,0,1,0,0,1,0,1,1, 4 clks each;
//      done on clk 40; ready returns 1 one clk after accept.
//   2. PARITY=1 / PARITY=2, word 8'hA5 -> parity bit 0 / 1. 8'h07 -> 1 / 0.
//      Frame 44 clks.
//   3. STOP=2, 8'h00 -> out low 36 clks, then high 8 clks; done at clk 44.
//   4. Back-to-back: accept 8'h3C, then 8'hC3 during the first frame.
//      -> ready=0 until the second frame starts; second start bit directly
//      follows stop bit; two done pulses 40 clks apart.
//   5. valid held high with ready=0 and d changing -> only the first d is sent.
//      No extra frame.
//   6. nrst low mid-DATA with a word buffered -> out=1, ready=1, done=0
//      immediately; no frame after release until a new accept.

Source files
------------

// File: rtl/uart_tx.sv
// UART transmitter: start bit, N data bits MSB first, optional parity, STOP stop bits.
// A one-word holding buffer lets the next word queue while a frame is on the line.
module uart_tx #(
    parameter int F      = 50_000_000,
    parameter int BR     = 115_200,
    parameter int L      = F / BR,
    parameter int N      = 8,
    parameter int M      = 3,
    parameter int PARITY = 0,
    parameter int STOP   = 1
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic [N-1:0] d,
    input  logic         valid,
    output logic         ready,
    output logic         out,
    output logic         done
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOPB
    } state_t;

    localparam logic [15:0]  LEN_LAST  = 16'(L - 1);
    localparam logic [15:0]  LEN_PRE   = 16'(L - 2);
    localparam logic [M-1:0] DATA_LAST = M'(N - 1);
    localparam logic [M-1:0] STOP_LAST = M'(STOP - 1);

    state_t       state;
    logic [15:0]  len_cnt;
    logic [M-1:0] bit_cnt;
    logic [N-1:0] shreg;
    logic [N-1:0] buf_data;
    logic         par_bit;

    function automatic logic parity_of(input logic [N-1:0] w);
        return (PARITY == 2) ? ~^w : ^w;
    endfunction

    // ready doubles as the "holding buffer empty" flag; accept needs it high
    // and reload needs it low, so the two writes below never collide.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state    <= IDLE;
            len_cnt  <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            buf_data <= '0;
            par_bit  <= 1'b0;
            ready    <= 1'b1;
            out      <= 1'b1;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;

            if (valid && ready) begin
                buf_data <= d;
                ready    <= 1'b0;
            end

            case (state)
                IDLE: begin
                    out     <= 1'b1;
                    len_cnt <= '0;
                    bit_cnt <= '0;
                    if (!ready) begin
                        shreg   <= buf_data;
                        par_bit <= parity_of(buf_data);
                        ready   <= 1'b1;
                        out     <= 1'b0;
                        state   <= START;
                    end
                end

                START: begin
                    if (len_cnt == LEN_LAST) begin
                        len_cnt <= '0;
                        bit_cnt <= '0;
                        out     <= shreg[N-1];
                        shreg   <= shreg << 1;
                        state   <= DATA;
                    end else begin
                        len_cnt <= len_cnt + 16'd1;
                    end
                end

                DATA: begin
                    if (len_cnt == LEN_LAST) begin
                        len_cnt <= '0;
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt <= '0;
                            if (PARITY != 0) begin
                                out   <= par_bit;
                                state <= PAR;
                            end else begin
                                out   <= 1'b1;
                                state <= STOPB;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            out     <= shreg[N-1];
                            shreg   <= shreg << 1;
                        end
                    end else begin
                        len_cnt <= len_cnt + 16'd1;
                    end
                end

                PAR: begin
                    if (len_cnt == LEN_LAST) begin
                        len_cnt <= '0;
                        bit_cnt <= '0;
                        out     <= 1'b1;
                        state   <= STOPB;
                    end else begin
                        len_cnt <= len_cnt + 16'd1;
                    end
                end

                STOPB: begin
                    // Raised one edge early so done is high during the frame's final clock.
                    if (bit_cnt == STOP_LAST && len_cnt == LEN_PRE) begin
                        done <= 1'b1;
                    end
                    if (len_cnt == LEN_LAST) begin
                        len_cnt <= '0;
                        if (bit_cnt == STOP_LAST) begin
                            bit_cnt <= '0;
                            if (!ready) begin
                                shreg   <= buf_data;
                                par_bit <= parity_of(buf_data);
                                ready   <= 1'b1;
                                out     <= 1'b0;
                                state   <= START;
                            end else begin
                                out   <= 1'b1;
                                state <= IDLE;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        len_cnt <= len_cnt + 16'd1;
                    end
                end

                default: begin
                    out   <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at L=4: four instances cover no parity, even, odd and two stop bits.
// Expected line levels are hand-written frames, transmitted bit first on the left.
module tb_uart_tx;

    logic       clk;
    logic       nrst;
    logic [7:0] d;
    logic [3:0] valid;
    logic [3:0] ready;
    logic [3:0] tx_out;
    logic [3:0] done;

    int total = 0;
    int bad   = 0;

    uart_tx #(.F(1_000_000), .BR(250_000), .PARITY(0), .STOP(1)) u0 (
        .clk(clk), .nrst(nrst), .d(d), .valid(valid[0]),
        .ready(ready[0]), .out(tx_out[0]), .done(done[0]));
    uart_tx #(.F(1_000_000), .BR(250_000), .PARITY(1), .STOP(1)) u1 (
        .clk(clk), .nrst(nrst), .d(d), .valid(valid[1]),
        .ready(ready[1]), .out(tx_out[1]), .done(done[1]));
    uart_tx #(.F(1_000_000), .BR(250_000), .PARITY(2), .STOP(1)) u2 (
        .clk(clk), .nrst(nrst), .d(d), .valid(valid[2]),
        .ready(ready[2]), .out(tx_out[2]), .done(done[2]));
    uart_tx #(.F(1_000_000), .BR(250_000), .PARITY(0), .STOP(2)) u3 (
        .clk(clk), .nrst(nrst), .d(d), .valid(valid[3]),
        .ready(ready[3]), .out(tx_out[3]), .done(done[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Presents one word on instance idx for exactly one rising edge.
    task automatic apply_stimulus(input int idx, input logic [7:0] word);
        @(negedge clk);
        check_output($sformatf("u%0d ready before accept", idx), 32'(ready[idx]), 32'd1);
        d          = word;
        valid[idx] = 1'b1;
        @(posedge clk);
        #1;
        valid[idx] = 1'b0;
    endtask

    task automatic check_frame(input int idx, input logic [0:11] bits, input int nbits);
        int last;
        last = nbits * 4;
        for (int i = 1; i <= last; i++) begin
            @(posedge clk);
            #1;
            check_output($sformatf("u%0d out clk%0d", idx, i), 32'(tx_out[idx]),
                         32'(bits[(i - 1) / 4]));
            check_output($sformatf("u%0d done clk%0d", idx, i), 32'(done[idx]),
                         32'(i == last));
            if (i == 1)
                check_output($sformatf("u%0d ready after accept", idx), 32'(ready[idx]), 32'd1);
        end
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk);
            #1;
            check_output($sformatf("u%0d idle out %0d", idx, i), 32'(tx_out[idx]), 32'd1);
            check_output($sformatf("u%0d idle done %0d", idx, i), 32'(done[idx]), 32'd0);
        end
    endtask

    // Frame one is already accepted; word2 is offered at clk s and valid stays
    // high (with d scrambled) through clk h while the buffer is full.
    task automatic check_pair(input logic [0:9] first, input logic [0:9] second,
                              input logic [7:0] word2, input int s, input int h);
        int   j;
        logic exp_out;
        for (int i = 1; i <= 88; i++) begin
            @(posedge clk);
            #1;
            j = (i - 1) / 4;
            if (i > 80)
                exp_out = 1'b1;
            else if (j < 10)
                exp_out = first[j];
            else
                exp_out = second[j - 10];
            check_output($sformatf("pair out clk%0d", i), 32'(tx_out[0]), 32'(exp_out));
            check_output($sformatf("pair done clk%0d", i), 32'(done[0]),
                         32'(i == 40 || i == 80));
            check_output($sformatf("pair ready clk%0d", i), 32'(ready[0]),
                         32'(!(i >= s && i <= 40)));
            if (i == s - 1) begin
                d        = word2;
                valid[0] = 1'b1;
            end else if (i >= s && i < h) begin
                d = 8'(i * 37 + 1);
            end
            if (i == h)
                valid[0] = 1'b0;
        end
    endtask

    initial begin
        nrst  = 1'b0;
        valid = 4'b0000;
        d     = 8'h00;
        #12;
        for (int k = 0; k < 4; k++) begin
            check_output($sformatf("u%0d reset out", k), 32'(tx_out[k]), 32'd1);
            check_output($sformatf("u%0d reset ready", k), 32'(ready[k]), 32'd1);
            check_output($sformatf("u%0d reset done", k), 32'(done[k]), 32'd0);
        end
        @(negedge clk);
        nrst = 1'b1;
        repeat (3) @(posedge clk);

        apply_stimulus(0, 8'hA5);
        check_frame(0, 12'b0_10100101_100, 10);

        apply_stimulus(1, 8'hA5);
        check_frame(1, 12'b0_10100101_010, 11);
        apply_stimulus(2, 8'hA5);
        check_frame(2, 12'b0_10100101_110, 11);
        apply_stimulus(1, 8'h07);
        check_frame(1, 12'b0_00000111_110, 11);
        apply_stimulus(2, 8'h07);
        check_frame(2, 12'b0_00000111_010, 11);

        apply_stimulus(3, 8'h00);
        check_frame(3, 12'b0_00000000_110, 11);

        apply_stimulus(0, 8'h3C);
        check_pair(10'b0_00111100_1, 10'b0_11000011_1, 8'hC3, 10, 10);

        apply_stimulus(0, 8'h5A);
        check_pair(10'b0_01011010_1, 10'b0_10000001_1, 8'h81, 5, 30);

        apply_stimulus(0, 8'hA5);
        for (int i = 1; i <= 18; i++) begin
            @(posedge clk);
            #1;
            if (i == 2) begin
                d        = 8'h0F;
                valid[0] = 1'b1;
            end
            if (i == 3)
                valid[0] = 1'b0;
        end
        check_output("pre-reset out", 32'(tx_out[0]), 32'd0);
        check_output("pre-reset ready", 32'(ready[0]), 32'd0);
        nrst = 1'b0;
        #1;
        check_output("async reset out", 32'(tx_out[0]), 32'd1);
        check_output("async reset ready", 32'(ready[0]), 32'd1);
        check_output("async reset done", 32'(done[0]), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        nrst = 1'b1;
        for (int i = 1; i <= 50; i++) begin
            @(posedge clk);
            #1;
            check_output($sformatf("post-reset out %0d", i), 32'(tx_out[0]), 32'd1);
            check_output($sformatf("post-reset ready %0d", i), 32'(ready[0]), 32'd1);
            check_output($sformatf("post-reset done %0d", i), 32'(done[0]), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
